rope_bounce_ctrl: RTL

//  Upstream direction controller for the rope mover. Samples rope X each frame and a latched

---
 rtl/rope_bounce_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/rope_bounce_ctrl.sv
// rope_bounce_ctrl: per-frame rope edge/collision check issuing one-clock dirToggle pulses with cooldown.
// ROPE_COLLISION_TOGGLE_EN enables the latched collision as a toggle trigger.
module rope_bounce_ctrl #(
    parameter int LEFT_BOUND      = 0,
    parameter int RIGHT_BOUND     = 639,
    parameter int ROPE_WIDTH      = 32,
    parameter int COOLDOWN_FRAMES = 4,
    parameter bit INIT_DIR_RIGHT  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start_of_frame,
    input  logic signed [10:0] i_top_left_x,
    input  logic               i_collision,
    output logic               o_dir_toggle,
    output logic               o_dir_right,
    output logic [7:0]         o_bounce_count
);
    localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic signed [11:0] L_B = 12'(LEFT_BOUND);
    localparam logic signed [11:0] R_B = 12'(RIGHT_BOUND);
    localparam logic signed [11:0] R_W = 12'(ROPE_WIDTH);
`ifdef ROPE_COLLISION_TOGGLE_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, FIRE, COOLDOWN} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_lat, r_toggle, r_dir;
    logic [7:0]         r_count;
    logic signed [11:0] w_x;
    logic               w_hit, w_trig;

    assign w_x    = {i_top_left_x[10], i_top_left_x};
    // 12-bit signed compare keeps X+ROPE_WIDTH free of overflow
    assign w_hit  = (!r_dir && w_x <= L_B) || (r_dir && w_x + R_W >= R_B);
    assign w_trig = i_start_of_frame && (w_hit || (COLL_EN && (r_lat || i_collision)));

    always_comb begin
        w_next = r_state;
        if (r_state == RUN && w_trig)
            w_next = FIRE;
        else if (r_state == FIRE)
            w_next = COOLDOWN_FRAMES > 0 ? COOLDOWN : RUN;
        else if (r_state == COOLDOWN && i_start_of_frame && r_cnt <= CW'(1))
            w_next = RUN;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= RUN;
            r_toggle <= 1'b0;
            r_dir    <= INIT_DIR_RIGHT;
            r_count  <= 8'd0;
            r_cnt    <= '0;
            r_lat    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_toggle <= w_next == FIRE;
            r_lat    <= COLL_EN && !i_start_of_frame && (r_lat || i_collision);
            if (w_next == FIRE) begin
                r_dir   <= ~r_dir;
                r_count <= r_count + 8'(r_count != 8'hFF);
                r_cnt   <= CW'(COOLDOWN_FRAMES);
            end else if (r_state == COOLDOWN && i_start_of_frame) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_dir_toggle   = r_toggle;
    assign o_dir_right    = r_dir;
    assign o_bounce_count = r_count;
endmodule
